// File: rtl/pyrx_pkg.sv
// Shared constants and state encoding for the RX payload word packer.
package pyrx_pkg;

  localparam int WORD_W = 32;
  localparam int ADDR_W = 8;
  localparam int CNT_W  = 13;
  localparam int BIT_W  = $clog2(WORD_W);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    FLUSH,
    DONE
  } state_e;

endpackage

// File: rtl/pyrx_wordpack.sv
// Packs the decoded RX payload bit stream LSB-first into 32-bit buffer words.
// Optional macro PYRX_ZEROPAD_EN clears the shift word after every completed write.
module pyrx_wordpack
  import pyrx_pkg::*;
(
  input  logic              clk_6M,
  input  logic              rst,
  input  logic              dec_py_st_p,
  input  logic              dec_pybit,
  input  logic              dec_pybit_valid,
  input  logic              py_endp,
  output logic [ADDR_W-1:0] rxlnctrl_addr,
  output logic [WORD_W-1:0] rxlnctrl_din,
  output logic              rxlnctrl_we,
  output logic [CNT_W-1:0]  rx_bitcount,
  output logic              rxpy_done_p,
  output logic              rxpy_ovf
);

  localparam logic [CNT_W:0] CNT_ONE = {{CNT_W{1'b0}}, 1'b1};

  state_e            state_q;
  logic [CNT_W:0]    cnt_q;      // MSB marks saturation at 2^CNT_W bits
  logic [WORD_W-1:0] word_q;
  logic [WORD_W-1:0] word_d;
  logic [ADDR_W-1:0] addr_q;
  logic [WORD_W-1:0] din_q;
  logic              we_q;
  logic              done_q;
  logic              ovf_q;

  logic [BIT_W-1:0]  bit_idx;
  logic              saturated;
  logic              accept;

  assign bit_idx   = cnt_q[BIT_W-1:0];
  assign saturated = cnt_q[CNT_W];
  assign accept    = (state_q == COLLECT) && dec_pybit_valid && !saturated;

  // NOTE: default the whole word before the indexed write so no latch is inferred.
  always_comb begin
    word_d          = word_q;
    word_d[bit_idx] = dec_pybit;
  end

  // NOTE: all state and registered outputs use non-blocking assignments; reset is synchronous.
  always_ff @(posedge clk_6M) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      if (dec_py_st_p) begin
        // Restart drops any payload in progress, including a not-yet-issued flush.
        state_q <= COLLECT;
        cnt_q   <= '0;
        word_q  <= '0;
        ovf_q   <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: ;
          COLLECT: begin
            if (accept) begin
              cnt_q <= cnt_q + CNT_ONE;
              if (bit_idx == '1) begin
                we_q   <= 1'b1;
                addr_q <= cnt_q[CNT_W-1:BIT_W];
                din_q  <= word_d;
`ifdef PYRX_ZEROPAD_EN
                word_q <= '0;
`else
                word_q <= word_d;
`endif
              end else begin
                word_q <= word_d;
              end
            end else if (dec_pybit_valid && saturated) begin
              ovf_q <= 1'b1;
            end
            if (py_endp) state_q <= FLUSH;
          end
          FLUSH: begin
            // A word completed by the last bit leaves bit_idx at 0, so no second write.
            if (bit_idx != '0) begin
              we_q   <= 1'b1;
              addr_q <= cnt_q[CNT_W-1:BIT_W];
              din_q  <= word_q;
            end else begin
              done_q <= 1'b1;
            end
            state_q <= DONE;
          end
          DONE: begin
            // Flush write on the outputs now: done follows it by one cycle.
            done_q  <= we_q;
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign rxlnctrl_addr = addr_q;
  assign rxlnctrl_din  = din_q;
  assign rxlnctrl_we   = we_q;
  assign rxpy_done_p   = done_q;
  assign rxpy_ovf      = ovf_q;
  assign rx_bitcount   = saturated ? {CNT_W{1'b1}} : cnt_q[CNT_W-1:0];

endmodule

// File: tb/tb_pyrx_wordpack.sv
// Self-checking bench for pyrx_wordpack: randomized payloads against a bit-list reference model.
module tb_pyrx_wordpack;
  import pyrx_pkg::*;

`ifdef PYRX_ZEROPAD_EN
  localparam bit ZP = 1'b1;
`else
  localparam bit ZP = 1'b0;
`endif

  logic              clk_6M = 1'b0;
  logic              rst = 1'b1;
  logic              dec_py_st_p = 1'b0;
  logic              dec_pybit = 1'b0;
  logic              dec_pybit_valid = 1'b0;
  logic              py_endp = 1'b0;
  logic [ADDR_W-1:0] rxlnctrl_addr;
  logic [WORD_W-1:0] rxlnctrl_din;
  logic              rxlnctrl_we;
  logic [CNT_W-1:0]  rx_bitcount;
  logic              rxpy_done_p;
  logic              rxpy_ovf;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int                cyc;
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] din;
  } wr_t;

  wr_t wr_log[$];
  int  done_log[$];

  pyrx_wordpack dut (
    .clk_6M          (clk_6M),
    .rst             (rst),
    .dec_py_st_p     (dec_py_st_p),
    .dec_pybit       (dec_pybit),
    .dec_pybit_valid (dec_pybit_valid),
    .py_endp         (py_endp),
    .rxlnctrl_addr   (rxlnctrl_addr),
    .rxlnctrl_din    (rxlnctrl_din),
    .rxlnctrl_we     (rxlnctrl_we),
    .rx_bitcount     (rx_bitcount),
    .rxpy_done_p     (rxpy_done_p),
    .rxpy_ovf        (rxpy_ovf)
  );

  always #5 clk_6M = ~clk_6M;

  always @(posedge clk_6M) cyc <= cyc + 1;

  // Outputs are logged mid-cycle, tagged with the cycle they are visible in.
  always @(negedge clk_6M) begin
    if (rxlnctrl_we === 1'b1) wr_log.push_back('{cyc, rxlnctrl_addr, rxlnctrl_din});
    if (rxpy_done_p === 1'b1) done_log.push_back(cyc);
  end

  // Inputs presented during the current cycle, sampled at the next rising edge.
  task automatic drive(input logic v, input logic b, input logic st, input logic ep);
    dec_pybit_valid = v;
    dec_pybit       = b;
    dec_py_st_p     = st;
    py_endp         = ep;
    @(posedge clk_6M);
    #1;
  endtask

  // mode 0: random bits, 1: bit = i[0], 2: all ones.
  task automatic run_payload(input string name, input int n, input int mode, input int gap_max,
                             input bit coinc, input int abort_n);
    logic              acc[$];
    int                acc_cyc[$];
    wr_t               exp_wr[$];
    int                p_cyc, last_we, exp_done, nacc, nw, rem, nmin;
    logic              b;
    logic [WORD_W-1:0] w, prev;
    logic [CNT_W-1:0]  exp_cnt;
    logic              exp_ovf;
    bit                back2back;

    wr_log.delete();
    done_log.delete();
    p_cyc = 0;
    if (abort_n > 0) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < abort_n; i++) drive(1'b1, 1'($urandom_range(1, 0)), 1'b0, 1'b0);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < n; i++) begin
      for (int g = int'($urandom_range(gap_max, 0)); g > 0; g--)
        drive(1'b0, 1'($urandom_range(1, 0)), 1'b0, 1'b0);
      case (mode)
        0:       b = 1'($urandom_range(1, 0));
        1:       b = i[0];
        default: b = 1'b1;
      endcase
      if (acc.size() < (1 << CNT_W)) begin
        acc.push_back(b);
        acc_cyc.push_back(cyc);
      end
      if (coinc && i == n - 1) p_cyc = cyc;
      drive(1'b1, b, 1'b0, coinc && i == n - 1);
    end
    if (!coinc || n == 0) begin
      for (int g = int'($urandom_range(gap_max, 0)); g > 0; g--) drive(1'b0, 1'b0, 1'b0, 1'b0);
      p_cyc = cyc;
      drive(1'b0, 1'b0, 1'b0, 1'b1);
    end
    repeat (6) drive(1'b0, 1'b0, 1'b0, 1'b0);

    // Reference: word k holds accepted bits 32k..32k+31, written the cycle after its last bit.
    nacc    = acc.size();
    nw      = nacc / WORD_W;
    rem     = nacc % WORD_W;
    prev    = '0;
    last_we = -1;
    for (int k = 0; k < nw; k++) begin
      for (int j = 0; j < WORD_W; j++) w[j] = acc[k * WORD_W + j];
      exp_wr.push_back('{acc_cyc[k * WORD_W + WORD_W - 1] + 1, ADDR_W'(k), w});
      last_we = acc_cyc[k * WORD_W + WORD_W - 1] + 1;
      prev    = w;
    end
    if (rem != 0) begin
      w = ZP ? '0 : prev;
      for (int j = 0; j < rem; j++) w[j] = acc[nw * WORD_W + j];
      exp_wr.push_back('{p_cyc + 2, ADDR_W'(nw), w});
      last_we = p_cyc + 2;
    end
    exp_done = (last_we + 1 > p_cyc + 2) ? last_we + 1 : p_cyc + 2;
    exp_cnt  = (nacc >= (1 << CNT_W)) ? {CNT_W{1'b1}} : CNT_W'(nacc);
    exp_ovf  = (n > (1 << CNT_W));

    checks++;
    if (wr_log.size() != exp_wr.size()) begin
      errors++;
      $display("FAIL %s write_count got %0d want %0d", name, wr_log.size(), exp_wr.size());
    end
    nmin = (wr_log.size() < exp_wr.size()) ? wr_log.size() : exp_wr.size();
    for (int k = 0; k < nmin; k++) begin
      checks++;
      if (wr_log[k].cyc != exp_wr[k].cyc || wr_log[k].addr !== exp_wr[k].addr ||
          wr_log[k].din !== exp_wr[k].din) begin
        errors++;
        $display("FAIL %s write%0d got cyc=%0d addr=%0d din=%08h want cyc=%0d addr=%0d din=%08h",
                 name, k, wr_log[k].cyc, wr_log[k].addr, wr_log[k].din,
                 exp_wr[k].cyc, exp_wr[k].addr, exp_wr[k].din);
      end
    end
    checks++;
    if (done_log.size() != 1 || done_log[0] != exp_done) begin
      errors++;
      $display("FAIL %s done got count=%0d first=%0d want count=1 at %0d", name, done_log.size(),
               (done_log.size() > 0) ? done_log[0] : -1, exp_done);
    end
    checks++;
    if (rx_bitcount !== exp_cnt) begin
      errors++;
      $display("FAIL %s bitcount got %0d want %0d", name, rx_bitcount, exp_cnt);
    end
    checks++;
    if (rxpy_ovf !== exp_ovf) begin
      errors++;
      $display("FAIL %s ovf got %b want %b", name, rxpy_ovf, exp_ovf);
    end
    back2back = 1'b0;
    for (int k = 1; k < wr_log.size(); k++)
      if (wr_log[k].cyc == wr_log[k - 1].cyc + 1) back2back = 1'b1;
    checks++;
    if (back2back) begin
      errors++;
      $display("FAIL %s consecutive_we got 1 want 0", name);
    end
  endtask

  task automatic test_reset();
    repeat (2) drive(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({rxlnctrl_we, rxpy_done_p, rxpy_ovf} !== 3'b000 || rxlnctrl_addr !== '0 ||
        rxlnctrl_din !== '0 || rx_bitcount !== '0) begin
      errors++;
      $display("FAIL reset_outputs got we=%b done=%b ovf=%b addr=%0d din=%08h cnt=%0d want all 0",
               rxlnctrl_we, rxpy_done_p, rxpy_ovf, rxlnctrl_addr, rxlnctrl_din, rx_bitcount);
    end
    rst = 1'b0;
    // Valid bits before any payload start are ignored.
    repeat (40) drive(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (2) drive(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (rx_bitcount !== '0 || wr_log.size() != 0) begin
      errors++;
      $display("FAIL idle_ignore got cnt=%0d writes=%0d want 0 0", rx_bitcount, wr_log.size());
    end
  endtask

  task automatic test_alternating();
    run_payload("alternating", 64, 1, 0, 1'b1, 0);
    checks++;
    if (wr_log.size() < 2 || wr_log[0].din !== 32'hAAAA_AAAA || wr_log[1].din !== 32'hAAAA_AAAA ||
        wr_log[1].addr !== 8'd1) begin
      errors++;
      $display("FAIL alternating_words got n=%0d want two AAAAAAAA words", wr_log.size());
    end
  endtask

  task automatic test_ones_partial();
    logic [WORD_W-1:0] exp_flush;
    exp_flush = ZP ? 32'h0000_00FF : 32'hFFFF_FFFF;
    run_payload("ones40", 40, 2, 0, 1'b1, 0);
    checks++;
    if (wr_log.size() < 2 || wr_log[1].din !== exp_flush || wr_log[1].addr !== 8'd1) begin
      errors++;
      $display("FAIL ones40_flush got n=%0d din=%08h want %08h at addr 1", wr_log.size(),
               (wr_log.size() > 1) ? wr_log[1].din : 32'h0, exp_flush);
    end
  endtask

  task automatic test_zero_bits();
    run_payload("zero_bits", 0, 0, 0, 1'b0, 0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++)
      run_payload("random", int'($urandom_range(150, 1)), 0, 3, 1'($urandom_range(1, 0)), 0);
    run_payload("exact32", 32, 0, 1, 1'b0, 0);
    run_payload("one_bit", 1, 0, 0, 1'b1, 0);
  endtask

  task automatic test_overflow();
    run_payload("full8192", 1 << CNT_W, 0, 0, 1'b1, 0);
    run_payload("ovf8200", (1 << CNT_W) + 8, 0, 0, 1'b1, 0);
  endtask

  task automatic test_restart();
    run_payload("restart", 32, 0, 0, 1'b1, 20);
    checks++;
    if (wr_log.size() != 1 || rxpy_ovf !== 1'b0) begin
      errors++;
      $display("FAIL restart_single got writes=%0d ovf=%b want 1 0", wr_log.size(), rxpy_ovf);
    end
  endtask

  task automatic test_rst_mid();
    wr_log.delete();
    done_log.delete();
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 31; i++) drive(1'b1, 1'($urandom_range(1, 0)), 1'b0, 1'b0);
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    checks++;
    if ({rxlnctrl_we, rxpy_done_p, rxpy_ovf} !== 3'b000 || rxlnctrl_addr !== '0 ||
        rxlnctrl_din !== '0 || rx_bitcount !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs got we=%b done=%b ovf=%b addr=%0d din=%08h cnt=%0d want all 0",
               rxlnctrl_we, rxpy_done_p, rxpy_ovf, rxlnctrl_addr, rxlnctrl_din, rx_bitcount);
    end
    repeat (4) drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (4) drive(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (wr_log.size() != 0 || done_log.size() != 0 || rx_bitcount !== '0) begin
      errors++;
      $display("FAIL rst_mid_quiet got writes=%0d dones=%0d cnt=%0d want 0 0 0",
               wr_log.size(), done_log.size(), rx_bitcount);
    end
  endtask

  initial begin
    test_reset();
    test_alternating();
    test_ones_partial();
    test_zero_bits();
    test_random();
    test_overflow();
    test_restart();
    test_rst_mid();
    run_payload("after_rst", 45, 0, 2, 1'b0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
